// File: rtl/punc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// punc_fetch_unit_pkg : shared widths, reset PC and LC-3 opcode field defines
// Rev 1.0 : initial release
// ============================================================================
package punc_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h3000;

  // Opcode field position and the change-of-flow opcodes that cause redirects
  localparam int unsigned OC_HI   = 15;
  localparam int unsigned OC_LO   = 12;
  localparam logic [3:0]  OC_BR   = 4'b0000;
  localparam logic [3:0]  OC_JSR  = 4'b0100;
  localparam logic [3:0]  OC_JMP  = 4'b1100;
  localparam logic [3:0]  OC_TRAP = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/punc_fetch_unit.sv
`default_nettype none
// ============================================================================
// punc_fetch_unit : LC-3 instruction fetch with redirect squash and halt
// Rev 1.0 : initial release
// ============================================================================
module punc_fetch_unit
  import punc_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] npc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              squash_q, squash_d;
  logic              halt_pend_q, halt_pend_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

  assign mem_req  = (state_q == S_FETCH);
  assign mem_addr = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign npc      = ir_pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      pc_next_q   <= RESET_PC;
      squash_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_next_q   <= pc_next_d;
      squash_q    <= squash_d;
      halt_pend_q <= halt_pend_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_next_d   = pc_next_q;
    squash_d    = squash_q;
    halt_pend_d = halt_pend_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          squash_d    = 1'b0;
          halt_pend_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d    = S_HALTED;
            ir_valid_d = 1'b0;
          end else if (redirect) begin
            pc_d = redirect_pc;
          end else if (squash_q) begin
            pc_d = pc_next_q;
          end else begin
            ir_d       = mem_rdata;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end else if (redirect) begin
          // The in-flight request cannot be cancelled; remember where to go.
          pc_next_d = redirect_pc;
          squash_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (halt) begin
          state_d    = S_HALTED;
          ir_valid_d = 1'b0;
        end else if (redirect) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
          state_d    = S_FETCH;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_HALTED: begin
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d    = S_HALTED;
        ir_valid_d = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_punc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_punc_fetch_unit : directed plus random bench against a transaction model
// Rev 1.0 : initial release
// ============================================================================
module tb_punc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, ir_valid, ir_ready, redirect, halt;
  logic [15:0] mem_addr, mem_rdata, ir, ir_pc, npc, redirect_pc;

  logic        w_mem_req, w_mem_ack, w_ir_valid, w_ir_ready, w_redirect, w_halt;
  logic [15:0] w_mem_addr, w_mem_rdata, w_ir, w_ir_pc, w_npc, w_redirect_pc;

  int checks   = 0;
  int failures = 0;

  // Model of the expected flow: next fetch address and what is being held.
  logic        m_hold, m_halted, m_squash, m_halt_p;
  logic [15:0] m_addr, m_hold_pc, m_squash_pc;

  always #5 clk = ~clk;

  punc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h3000)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .npc(npc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  punc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
    .ir_valid(w_ir_valid), .ir(w_ir), .ir_pc(w_ir_pc), .npc(w_npc), .ir_ready(w_ir_ready),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .halt(w_halt)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] x;
    x = a ^ 16'h5A3C;
    return {x[6:0], x[15:7]} + 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    if (m_halted) begin
      chk("halted_req", 32'(mem_req), 32'd0);
      chk("halted_valid", 32'(ir_valid), 32'd0);
    end else if (m_hold) begin
      chk("hold_req", 32'(mem_req), 32'd0);
      chk("hold_valid", 32'(ir_valid), 32'd1);
      chk("hold_ir_pc", 32'(ir_pc), 32'(m_hold_pc));
      chk("hold_ir", 32'(ir), 32'(memf(m_hold_pc)));
      chk("hold_npc", 32'(npc), 32'(m_hold_pc + 16'd1));
    end else begin
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_addr", 32'(mem_addr), 32'(m_addr));
      chk("fetch_valid", 32'(ir_valid), 32'd0);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_halted = 1'b0; m_squash = 1'b0; m_halt_p = 1'b0;
    m_addr = 16'h3000; m_hold_pc = 16'h0; m_squash_pc = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_npc", 32'(npc), 32'd1);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'h3000);
  endtask

  task automatic step(input logic ack, input logic rdy, input logic rd,
                      input logic [15:0] rpc, input logic hlt);
    mem_ack     = ack;
    mem_rdata   = ack ? memf(mem_addr) : 16'($urandom);
    ir_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hlt;
    @(posedge clk);
    if (!m_halted) begin
      if (!m_hold) begin
        if (ack) begin
          if (hlt || m_halt_p) m_halted = 1'b1;
          else if (rd) m_addr = rpc;
          else if (m_squash) m_addr = m_squash_pc;
          else begin
            m_hold    = 1'b1;
            m_hold_pc = m_addr;
            m_addr    = m_addr + 16'd1;
          end
          m_squash = 1'b0;
          m_halt_p = 1'b0;
        end else if (hlt) begin
          m_halt_p = 1'b1;
        end else if (rd) begin
          m_squash    = 1'b1;
          m_squash_pc = rpc;
        end
      end else begin
        if (hlt) begin
          m_halted = 1'b1;
          m_hold   = 1'b0;
        end else if (rd) begin
          m_hold = 1'b0;
          m_addr = rpc;
        end else if (rdy) begin
          m_hold = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_step();
    logic ack;
    if (!m_hold && !m_halted) ack = ($urandom_range(0, 2) == 0);
    else                      ack = ($urandom_range(0, 15) == 0);
    step(ack, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
         16'($urandom), ($urandom_range(0, 249) == 0));
  endtask

  initial begin
    w_mem_ack = 1'b0; w_mem_rdata = 16'h0; w_ir_ready = 1'b0;
    w_redirect = 1'b0; w_redirect_pc = 16'h0; w_halt = 1'b0;
    do_reset();

    // PC wrap-around on the instance reset to 16'hFFFF
    chk("wrap_addr0", 32'(w_mem_addr), 32'hFFFF);
    w_mem_ack = 1'b1; w_mem_rdata = memf(16'hFFFF);
    @(posedge clk); @(negedge clk);
    chk("wrap_valid", 32'(w_ir_valid), 32'd1);
    chk("wrap_ir_pc", 32'(w_ir_pc), 32'hFFFF);
    chk("wrap_npc", 32'(w_npc), 32'h0000);
    w_mem_ack = 1'b0; w_ir_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wrap_addr1", 32'(w_mem_addr), 32'h0000);
    chk("wrap_req1", 32'(w_mem_req), 32'd1);
    w_ir_ready = 1'b0;

    do_reset();
    // Zero-wait memory, ready tied high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("zw_ir_pc", 32'(ir_pc), 32'(16'h3000 + 16'(i)));
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    chk("zw_addr3", 32'(mem_addr), 32'h3003);

    // Backpressure for 5 cycles
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("bp_req_after", 32'(mem_req), 32'd1);

    // Redirect in HOLD with a simultaneous ir_ready
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h4000, 1'b0);
    chk("rdh_addr", 32'(mem_addr), 32'h4000);

    // Redirect during a 3-wait-cycle fetch
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h5000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rdw_addr_stable", 32'(mem_addr), 32'h4000);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rdw_squash_valid", 32'(ir_valid), 32'd0);
    chk("rdw_new_addr", 32'(mem_addr), 32'h5000);

    // Redirect coinciding with ack
    step(1'b1, 1'b1, 1'b1, 16'h6000, 1'b0);
    chk("rda_addr", 32'(mem_addr), 32'h6000);

    // Halt in HOLD, then stray acks and redirects must not wake it
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 16'h7000, 1'b0);
    chk("halt_req", 32'(mem_req), 32'd0);

    // Halt while awaiting ack
    do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h8000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("haltw_valid", 32'(ir_valid), 32'd0);
    chk("haltw_req", 32'(mem_req), 32'd0);

    // Randomized traffic
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int i = 0; i < 400; i++) rand_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
